// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Brief    : Shared game-phase encoding, winner codes and spawn points.
//  Revision : 1.0
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        HIT_PAUSE = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_PLAYER = 2'b01;
    localparam logic [1:0] WIN_AI     = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    // Spawn points in screen pixels, shared with the tank blocks.
    localparam logic [9:0] SPAWN_PLAYER_X = 10'd80;
    localparam logic [9:0] SPAWN_PLAYER_Y = 10'd400;
    localparam logic [9:0] SPAWN_AI_X     = 10'd560;
    localparam logic [9:0] SPAWN_AI_Y     = 10'd80;

    function automatic logic [2:0] lives_after(input logic [2:0] lives, input logic hit);
        return (hit && (lives != 3'd0)) ? (lives - 3'd1) : lives;
    endfunction

    function automatic logic [1:0] winner_code(input logic player_out, input logic ai_out);
        if (player_out && ai_out) return WIN_DRAW;
        if (ai_out)               return WIN_PLAYER;
        if (player_out)           return WIN_AI;
        return WIN_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_state_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_ctrl_if
//  Brief    : Control/status bundle between entity logic and the game sequencer.
//  Revision : 1.0
// ============================================================================
interface game_state_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic               start_key;
    logic [1:0]         tank_death;
    logic [1:0]         AI_death;
    logic               play_enable;
    logic               respawn;
    logic               game_over;
    logic               banner_on;
    logic [1:0]         winner;
    logic [2:0]         player_lives;
    logic [2:0]         ai_lives;
    logic [SCORE_W-1:0] score;

    modport master (
        output start_key, tank_death, AI_death,
        input  play_enable, respawn, game_over, banner_on, winner,
               player_lives, ai_lives, score
    );

    modport slave (
        input  start_key, tank_death, AI_death,
        output play_enable, respawn, game_over, banner_on, winner,
               player_lives, ai_lives, score
    );
endinterface
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : frame_tick_gen
//  Brief    : Synchronises the VSync frame strobe and emits a 1-Clk rising-edge tick.
//  Revision : 1.0
// ============================================================================
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    // [0],[1] form the synchroniser; [2] holds the previous synced level.
    logic [2:0] r_sync;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_sync <= 3'b000;
        else       r_sync <= {r_sync[1:0], frame_clk};
    end

    assign tick = r_sync[1] & ~r_sync[2];
endmodule
`default_nettype wire

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_ctrl
//  Brief    : Game sequencer: title/play/hit-pause/game-over, lives, score, banner blink.
//  Revision : 1.0
// ============================================================================
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int PAUSE_FRAMES = 60,
    parameter int BLINK_FRAMES = 30,
    parameter int SCORE_W      = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    game_state_ctrl_if.slave bus
);
    localparam int PW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0]      c_pause_last = PW'(PAUSE_FRAMES - 1);
    localparam logic [BW-1:0]      c_blink_last = BW'(BLINK_FRAMES - 1);
    localparam logic [2:0]         c_lives      = 3'(LIVES);
    localparam logic [SCORE_W-1:0] c_score_max  = {SCORE_W{1'b1}};

    game_state_t        r_state, w_state_next;
    logic               w_tick;
    logic               r_start_prev, r_player_prev, r_ai_prev;
    logic               r_play_enable, r_respawn, r_game_over, r_banner_on;
    logic [1:0]         r_winner;
    logic [2:0]         r_player_lives, r_ai_lives;
    logic [SCORE_W-1:0] r_score;
    logic [PW-1:0]      r_frame_cnt;
    logic [BW-1:0]      r_blink_cnt;

    logic               w_start_edge, w_player_hit, w_ai_hit;
    logic [2:0]         w_player_lives_hit, w_ai_lives_hit;
    logic               w_respawn, w_start_game, w_count_hits, w_enter_over;
    logic               w_pause_restart, w_pause_step, w_blink_step, w_leave_over;

    frame_tick_gen u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (w_tick)
    );

    assign w_start_edge       = bus.start_key & ~r_start_prev;
    assign w_player_hit       = (|bus.tank_death) & ~r_player_prev;
    assign w_ai_hit           = (|bus.AI_death) & ~r_ai_prev;
    assign w_player_lives_hit = lives_after(r_player_lives, w_player_hit);
    assign w_ai_lives_hit     = lives_after(r_ai_lives, w_ai_hit);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        w_respawn       = 1'b0;
        w_start_game    = 1'b0;
        w_count_hits    = 1'b0;
        w_enter_over    = 1'b0;
        w_pause_restart = 1'b0;
        w_pause_step    = 1'b0;
        w_blink_step    = 1'b0;
        w_leave_over    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_edge) begin
                    w_state_next = PLAY;
                    w_respawn    = 1'b1;
                    w_start_game = 1'b1;
                end
            end
            PLAY: begin
                w_count_hits = 1'b1;
                if ((w_player_lives_hit == 3'd0) || (w_ai_lives_hit == 3'd0)) begin
                    w_state_next = GAME_OVER;
                    w_enter_over = 1'b1;
                end else if (w_player_hit || w_ai_hit) begin
                    w_state_next    = HIT_PAUSE;
                    w_pause_restart = 1'b1;
                end
            end
            HIT_PAUSE: begin
                if (w_tick) begin
                    if (r_frame_cnt == c_pause_last) begin
                        w_state_next = PLAY;
                        w_respawn    = 1'b1;
                    end else begin
                        w_pause_step = 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                w_blink_step = w_tick;
                if (w_start_edge) begin
                    w_state_next = IDLE;
                    w_leave_over = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_start_prev   <= 1'b0;
            r_player_prev  <= 1'b0;
            r_ai_prev      <= 1'b0;
            r_play_enable  <= 1'b0;
            r_respawn      <= 1'b0;
            r_game_over    <= 1'b0;
            r_banner_on    <= 1'b0;
            r_winner       <= WIN_NONE;
            r_player_lives <= c_lives;
            r_ai_lives     <= c_lives;
            r_score        <= '0;
            r_frame_cnt    <= '0;
            r_blink_cnt    <= '0;
        end else begin
            r_start_prev  <= bus.start_key;
            r_player_prev <= |bus.tank_death;
            r_ai_prev     <= |bus.AI_death;
            r_respawn     <= w_respawn;
            r_play_enable <= (w_state_next == PLAY);
            r_game_over   <= (w_state_next == GAME_OVER);

            if (w_start_game) begin
                r_player_lives <= c_lives;
                r_ai_lives     <= c_lives;
                r_score        <= '0;
                r_winner       <= WIN_NONE;
            end else if (w_count_hits) begin
                r_player_lives <= w_player_lives_hit;
                r_ai_lives     <= w_ai_lives_hit;
                if (w_ai_hit && (r_score != c_score_max))
                    r_score <= r_score + SCORE_W'(1);
            end

            // Winner is decided from the post-hit lives, so a same-cycle double kill reads as a draw.
            if (w_enter_over) begin
                r_winner    <= winner_code(w_player_lives_hit == 3'd0, w_ai_lives_hit == 3'd0);
                r_banner_on <= 1'b1;
                r_blink_cnt <= '0;
            end else if (w_leave_over) begin
                r_banner_on <= 1'b0;
            end else if (w_blink_step) begin
                if (r_blink_cnt == c_blink_last) begin
                    r_blink_cnt <= '0;
                    r_banner_on <= ~r_banner_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end

            if (w_pause_restart)   r_frame_cnt <= '0;
            else if (w_pause_step) r_frame_cnt <= r_frame_cnt + PW'(1);
        end
    end

    assign bus.play_enable  = r_play_enable;
    assign bus.respawn      = r_respawn;
    assign bus.game_over    = r_game_over;
    assign bus.banner_on    = r_banner_on;
    assign bus.winner       = r_winner;
    assign bus.player_lives = r_player_lives;
    assign bus.ai_lives     = r_ai_lives;
    assign bus.score        = r_score;
endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_state_ctrl
//  Brief    : Directed self-checking bench for game_state_ctrl (small pause/blink/score sizes).
//  Revision : 1.0
// ============================================================================
module tb_game_state_ctrl;
    localparam int LIVES        = 5;
    localparam int PAUSE_FRAMES = 4;
    localparam int BLINK_FRAMES = 3;
    localparam int SCORE_W      = 2;

    logic Clk       = 1'b0;
    logic Reset     = 1'b1;
    logic frame_clk = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   r;

    game_state_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

    game_state_ctrl #(
        .LIVES        (LIVES),
        .PAUSE_FRAMES (PAUSE_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .SCORE_W      (SCORE_W)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame strobe; the resulting tick lands inside the 8 Clk window.
    task automatic frame_pulse(output int resp);
        resp = 0;
        frame_clk = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            if (bus.respawn === 1'b1) resp++;
        end
        frame_clk = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            if (bus.respawn === 1'b1) resp++;
        end
    endtask

    task automatic finish_pause(input string tag);
        int rr;
        int total;
        total = 0;
        for (int i = 0; i < PAUSE_FRAMES; i++) begin
            frame_pulse(rr);
            total += rr;
            if (i == PAUSE_FRAMES - 2) check({tag, " frozen"}, bus.play_enable, 0);
        end
        check({tag, " respawn"}, total, 1);
        check({tag, " resumed"}, bus.play_enable, 1);
    endtask

    task automatic hit(input logic [1:0] p, input logic [1:0] a);
        bus.tank_death = p;
        bus.AI_death   = a;
        @(negedge Clk);
        bus.tank_death = 2'b00;
        bus.AI_death   = 2'b00;
    endtask

    task automatic press_start();
        bus.start_key = 1'b1;
        @(negedge Clk);
        bus.start_key = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_key  = 1'b0;
        bus.tank_death = 2'b00;
        bus.AI_death   = 2'b00;
        repeat (3) @(negedge Clk);
        check("rst play_enable", bus.play_enable, 0);
        check("rst respawn", bus.respawn, 0);
        check("rst game_over", bus.game_over, 0);
        check("rst banner", bus.banner_on, 0);
        check("rst winner", bus.winner, 2'b00);
        check("rst p_lives", bus.player_lives, 5);
        check("rst a_lives", bus.ai_lives, 5);
        check("rst score", bus.score, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Deaths in IDLE are not counted
        hit(2'b01, 2'b01);
        @(negedge Clk);
        check("idle p_lives", bus.player_lives, 5);
        check("idle a_lives", bus.ai_lives, 5);
        check("idle play", bus.play_enable, 0);

        // T1: start, held key does not retrigger
        bus.start_key = 1'b1;
        @(negedge Clk);
        check("t1 respawn", bus.respawn, 1);
        check("t1 play", bus.play_enable, 1);
        check("t1 lives", {bus.player_lives, bus.ai_lives}, {3'd5, 3'd5});
        check("t1 score", bus.score, 0);
        @(negedge Clk);
        check("t1 respawn 1clk", bus.respawn, 0);
        repeat (2) @(negedge Clk);
        check("t1 held play", bus.play_enable, 1);
        check("t1 held respawn", bus.respawn, 0);
        bus.start_key = 1'b0;

        // T2: AI death held high counts once
        bus.AI_death = 2'b01;
        @(negedge Clk);
        check("t2 a_lives", bus.ai_lives, 4);
        check("t2 score", bus.score, 1);
        check("t2 pause", bus.play_enable, 0);
        check("t2 p_lives", bus.player_lives, 5);
        hit(2'b11, 2'b01);
        check("t2 pause death ignored", bus.player_lives, 5);
        press_start();
        @(negedge Clk);
        check("t2 start ignored", bus.play_enable, 0);
        bus.AI_death = 2'b01;
        finish_pause("t2");
        repeat (3) @(negedge Clk);
        check("t2 held a_lives", bus.ai_lives, 4);
        check("t2 held score", bus.score, 1);
        check("t2 held play", bus.play_enable, 1);
        bus.AI_death = 2'b00;
        repeat (2) @(negedge Clk);

        // T3: player loses all lives
        for (int i = 0; i < LIVES - 1; i++) begin
            hit(2'b10, 2'b00);
            check("t3 p_lives", bus.player_lives, 32'(4 - i));
            finish_pause("t3");
        end
        hit(2'b01, 2'b00);
        check("t3 p_lives 0", bus.player_lives, 0);
        check("t3 game_over", bus.game_over, 1);
        check("t3 winner", bus.winner, 2'b10);
        check("t3 banner entry", bus.banner_on, 1);
        check("t3 play", bus.play_enable, 0);
        check("t3 a_lives", bus.ai_lives, 4);
        frame_pulse(r);
        frame_pulse(r);
        check("t3 banner 2 ticks", bus.banner_on, 1);
        frame_pulse(r);
        check("t3 banner 3 ticks", bus.banner_on, 0);
        repeat (3) frame_pulse(r);
        check("t3 banner 6 ticks", bus.banner_on, 1);
        check("t3 no respawn", r, 0);
        hit(2'b00, 2'b01);
        check("t3 over a_lives", bus.ai_lives, 4);

        // GAME_OVER -> IDLE -> PLAY with reload
        press_start();
        check("t6 idle game_over", bus.game_over, 0);
        check("t6 idle banner", bus.banner_on, 0);
        check("t6 idle play", bus.play_enable, 0);
        check("t6 idle winner held", bus.winner, 2'b10);
        @(negedge Clk);
        bus.start_key = 1'b1;
        @(negedge Clk);
        bus.start_key = 1'b0;
        check("t6 restart play", bus.play_enable, 1);
        check("t6 restart respawn", bus.respawn, 1);
        check("t6 restart lives", {bus.player_lives, bus.ai_lives}, {3'd5, 3'd5});
        check("t6 restart score", bus.score, 0);
        check("t6 restart winner", bus.winner, 2'b00);

        // Score saturation, then same-cycle double kill at 1/1
        for (int i = 0; i < LIVES - 1; i++) begin
            hit(2'b00, 2'b10);
            check("t6 a_lives", bus.ai_lives, 32'(4 - i));
            check("t6 score", bus.score, (i < 3) ? 32'(i + 1) : 32'd3);
            finish_pause("t6");
        end
        for (int i = 0; i < LIVES - 1; i++) begin
            hit(2'b10, 2'b00);
            check("t4 p_lives", bus.player_lives, 32'(4 - i));
            finish_pause("t4");
        end
        hit(2'b01, 2'b11);
        check("t4 lives", {bus.player_lives, bus.ai_lives}, 6'd0);
        check("t4 winner", bus.winner, 2'b11);
        check("t4 score sat", bus.score, 3);
        check("t4 game_over", bus.game_over, 1);
        check("t4 play", bus.play_enable, 0);

        // T5: async reset in HIT_PAUSE
        press_start();
        @(negedge Clk);
        press_start();
        check("t5 play", bus.play_enable, 1);
        hit(2'b00, 2'b01);
        check("t5 score", bus.score, 1);
        frame_pulse(r);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("t5 rst lives", {bus.player_lives, bus.ai_lives}, {3'd5, 3'd5});
        check("t5 rst score", bus.score, 0);
        check("t5 rst play", bus.play_enable, 0);
        check("t5 rst game_over", bus.game_over, 0);
        check("t5 rst banner", bus.banner_on, 0);
        check("t5 rst winner", bus.winner, 2'b00);
        check("t5 rst respawn", bus.respawn, 0);
        @(negedge Clk);
        Reset = 1'b0;
        begin
            int total;
            total = 0;
            for (int i = 0; i < PAUSE_FRAMES; i++) begin
                frame_pulse(r);
                total += r;
            end
            check("t5 idle no respawn", total, 0);
        end
        check("t5 idle play", bus.play_enable, 0);
        bus.start_key = 1'b1;
        @(negedge Clk);
        bus.start_key = 1'b0;
        check("t5 start respawn", bus.respawn, 1);
        check("t5 start play", bus.play_enable, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
